s2mm_burst_writer: RTL
======================

S2MM_BURST_WRITER -- requirements
Module: s2mm_burst_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning AXI/stream data width in bits (64, 128 or 256).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning AXI address width.
REQ-003 SHALL have parameter MAX_BURST_LEN, default 16, meaning maximum beats per AXI burst (1..256).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, meaning maximum AW bursts issued without a B response (1..16).
REQ-005 SHALL have parameter LEN_WIDTH, default 16, meaning width of the command beat count.
REQ-006 SHALL have these ports (name, direction, width, meaning):
 m_axi_aclk  in  1  single clock.
 m_axi_aresetn  in  1  asynchronous active-low reset.
 cmd_valid/cmd_ready  in/out  1  command handshake.
 cmd_addr  in  ADDR_WIDTH  start byte address.
 cmd_beats  in  LEN_WIDTH  total beats to write.
 m_s2mm_axi_aw{addr,len,size,burst,cache,prot,valid,ready}  AXI4 write address channel.
 m_s2mm_axi_w{data,strb,last,valid,ready}  AXI4 write data channel; wstrb DATA_WIDTH/8 bits.
 m_s2mm_axi_b{resp,valid,ready}  AXI4 write response channel.
 s_s2mm_axis_t{data,valid,last,ready}  input stream.
 busy_o  out  1  command in progress.
 done_o  out  1  one-cycle completion pulse.
 resp_err_o  out  1  sticky: non-OKAY bresp seen in current command.
 tlast_err_o  out  1  sticky: stream tlast mismatched final beat.

Function
REQ-007 SHALL accept a command only when idle (cmd_ready = !busy_o); handshake sets busy_o next cycle and clears both error flags.
REQ-008 SHALL force cmd_addr low log2(DATA_WIDTH/8) bits to zero.
REQ-009 SHALL split the command into bursts of beats = min(remaining, MAX_BURST_LEN, beats to next 4 KiB boundary); awlen = beats-1.
REQ-010 SHALL drive awsize = log2(DATA_WIDTH/8), awburst = INCR, awcache = 4'b0011, awprot = 0, wstrb all ones.
REQ-011 SHALL hold awvalid and AW fields stable until awready; next burst address = previous + beats*DATA_WIDTH/8.
REQ-012 SHALL issue a new AW only when outstanding count < MAX_OUTSTANDING; outstanding +1 on AW handshake, -1 on B handshake, unchanged when both occur in one cycle.
REQ-013 SHALL push each issued burst length into a length FIFO; W path pops it and asserts wvalid/tready only while a burst is loaded.
REQ-014 SHALL pass tdata to wdata combinationally, wvalid = tvalid & loaded, tready = wready & loaded; wlast generated internally on the last beat of each burst.
REQ-015 SHALL ignore stream tlast for framing; set tlast_err_o if tlast differs from "final beat of command" on any accepted beat.
REQ-016 SHALL hold bready = 1; set resp_err_o on any bresp != 0.
REQ-017 SHALL pulse done_o and clear busy_o in the cycle after all AWs issued, all W beats sent and outstanding = 0.
REQ-018 SHALL treat cmd_beats = 0 as accepted, no AXI traffic, done_o two cycles after handshake.
REQ-019 SHALL allow AW of burst N+1 before W of burst N completes.

Reset
REQ-020 SHALL, on m_axi_aresetn low at any time, asynchronously clear awvalid, wvalid-internal state, busy_o, done_o, error flags, counters and FIFO; cmd_ready = 1 after release.
REQ-021 SHALL abandon an in-flight command on reset without completing AXI transactions.

Structure
REQ-022 SHALL place AXI burst/cache enums, 4 KiB constant and a log2 byte-count function in shared package dma_pkg.
REQ-023 SHALL implement the length FIFO as sub-module burst_len_fifo (depth MAX_OUTSTANDING, width 8).

Verification
REQ-024 addr 0x1000, beats 40, MAX_BURST_LEN 16 -> AWs len 15,15,7 at 0x1000,0x1080,0x1100; done_o once.
REQ-025 addr 0x0FF0, beats 8, DATA_WIDTH 64 -> AW len 1 at 0x0FF0, AW len 5 at 0x1000.
REQ-026 beats 128, bvalid withheld -> exactly MAX_OUTSTANDING=4 AWs, no 5th until first B.
REQ-027 bresp=2 on second of three bursts -> resp_err_o = 1 at done_o; cleared at next cmd handshake.
REQ-028 beats 10, tlast on beat 5 -> tlast_err_o = 1, all 10 beats still written.
REQ-029 aresetn low mid-burst -> awvalid/busy_o 0 immediately; fresh command completes normally.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared DMA definitions: AXI burst/cache encodings, the 4 KiB page size and a
// helper that turns a byte count into an AXI size exponent.
package dma_pkg;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [3:0] {
    AXI_CACHE_DEVICE_NONBUF = 4'b0000,
    AXI_CACHE_DEVICE_BUF    = 4'b0001,
    AXI_CACHE_NORMAL_NC_BUF = 4'b0011
  } axi_cache_e;

  localparam int BOUNDARY_4K = 4096;

  // Exponent of a power-of-two byte count (8 -> 3, 16 -> 4, 32 -> 5).
  function automatic int bytes_log2(input int bytes);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) == bytes) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/s2mm_burst_writer_if.sv
// AXI4 write channels plus the AXI-Stream input of the S2MM burst writer.
// master is the writer's view; slave is the memory/stream-source view.
interface s2mm_burst_writer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   m_s2mm_axi_awaddr;
  logic [7:0]              m_s2mm_axi_awlen;
  logic [2:0]              m_s2mm_axi_awsize;
  logic [1:0]              m_s2mm_axi_awburst;
  logic [3:0]              m_s2mm_axi_awcache;
  logic [2:0]              m_s2mm_axi_awprot;
  logic                    m_s2mm_axi_awvalid;
  logic                    m_s2mm_axi_awready;

  logic [DATA_WIDTH-1:0]   m_s2mm_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_s2mm_axi_wstrb;
  logic                    m_s2mm_axi_wlast;
  logic                    m_s2mm_axi_wvalid;
  logic                    m_s2mm_axi_wready;

  logic [1:0]              m_s2mm_axi_bresp;
  logic                    m_s2mm_axi_bvalid;
  logic                    m_s2mm_axi_bready;

  logic [DATA_WIDTH-1:0]   s_s2mm_axis_tdata;
  logic                    s_s2mm_axis_tvalid;
  logic                    s_s2mm_axis_tlast;
  logic                    s_s2mm_axis_tready;

  modport master (
    output m_s2mm_axi_awaddr, m_s2mm_axi_awlen, m_s2mm_axi_awsize, m_s2mm_axi_awburst,
    output m_s2mm_axi_awcache, m_s2mm_axi_awprot, m_s2mm_axi_awvalid,
    input  m_s2mm_axi_awready,
    output m_s2mm_axi_wdata, m_s2mm_axi_wstrb, m_s2mm_axi_wlast, m_s2mm_axi_wvalid,
    input  m_s2mm_axi_wready,
    input  m_s2mm_axi_bresp, m_s2mm_axi_bvalid,
    output m_s2mm_axi_bready,
    input  s_s2mm_axis_tdata, s_s2mm_axis_tvalid, s_s2mm_axis_tlast,
    output s_s2mm_axis_tready
  );

  modport slave (
    input  m_s2mm_axi_awaddr, m_s2mm_axi_awlen, m_s2mm_axi_awsize, m_s2mm_axi_awburst,
    input  m_s2mm_axi_awcache, m_s2mm_axi_awprot, m_s2mm_axi_awvalid,
    output m_s2mm_axi_awready,
    input  m_s2mm_axi_wdata, m_s2mm_axi_wstrb, m_s2mm_axi_wlast, m_s2mm_axi_wvalid,
    output m_s2mm_axi_wready,
    output m_s2mm_axi_bresp, m_s2mm_axi_bvalid,
    input  m_s2mm_axi_bready,
    output s_s2mm_axis_tdata, s_s2mm_axis_tvalid, s_s2mm_axis_tlast,
    input  s_s2mm_axis_tready
  );
endinterface

// File: rtl/burst_len_fifo.sv
// Small FIFO carrying issued burst lengths (awlen) from the AW side to the W side.
module burst_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr_q];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; clearing the pointers and count already makes
  // every stale entry unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/s2mm_burst_writer.sv
// Stream-to-memory writer: splits a (address, beat count) command into AXI4 INCR
// bursts that never cross 4 KiB and streams AXIS data straight onto the W channel.
module s2mm_burst_writer
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_beats,
  s2mm_burst_writer_if.master   axi,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  resp_err_o,
  output logic                  tlast_err_o
);
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int SIZE_LOG2 = bytes_log2(BYTES);
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic                  launch, finish;
  logic                  cmd_fire, aw_fire, w_fire, b_fire;
  logic                  aw_valid_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q, next_addr_q;
  logic [7:0]            aw_len_q;
  logic [LEN_WIDTH-1:0]  aw_remaining_q, w_remaining_q;
  logic [OUT_W-1:0]      outstanding_q;
  logic                  loaded_q;
  logic [7:0]            beat_cnt_q;
  logic                  done_q, resp_err_q, tlast_err_q;
  logic [12:0]           beats_to_4k;
  logic [31:0]           burst_beats;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [7:0]            fifo_dout;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy_o    = (state_q == ST_RUN);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign aw_fire   = aw_valid_q && axi.m_s2mm_axi_awready;
  assign w_fire    = axi.s_s2mm_axis_tvalid && loaded_q && axi.m_s2mm_axi_wready;
  assign b_fire    = axi.m_s2mm_axi_bvalid;  // bready is tied high
  assign fifo_pop  = !loaded_q && !fifo_empty;

  // Next burst size: the smallest of what is left, the burst cap and the
  // beats remaining before the next 4 KiB page.
  always_comb begin
    beats_to_4k = (13'(BOUNDARY_4K) - {1'b0, next_addr_q[11:0]}) >> SIZE_LOG2;
    burst_beats = 32'(MAX_BURST_LEN);
    if (32'(aw_remaining_q) < burst_beats) burst_beats = 32'(aw_remaining_q);
    if (32'(beats_to_4k) < burst_beats)    burst_beats = 32'(beats_to_4k);
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_RUN;
      ST_RUN: begin
        if (aw_remaining_q == '0 && !aw_valid_q && w_remaining_q == '0 &&
            outstanding_q == '0) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end else if (!aw_valid_q && aw_remaining_q != '0 && !fifo_full &&
                     outstanding_q < OUT_W'(MAX_OUTSTANDING)) begin
          launch = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // AW generation and outstanding-burst accounting.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      aw_valid_q     <= 1'b0;
      aw_addr_q      <= '0;
      aw_len_q       <= '0;
      next_addr_q    <= '0;
      aw_remaining_q <= '0;
      outstanding_q  <= '0;
    end else begin
      if (cmd_fire) begin
        next_addr_q    <= cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
        aw_remaining_q <= cmd_beats;
      end else if (launch) begin
        aw_valid_q     <= 1'b1;
        aw_addr_q      <= next_addr_q;
        aw_len_q       <= 8'(burst_beats - 32'd1);
        next_addr_q    <= next_addr_q + (ADDR_WIDTH'(burst_beats) << SIZE_LOG2);
        aw_remaining_q <= aw_remaining_q - LEN_WIDTH'(burst_beats);
      end
      if (aw_fire) aw_valid_q <= 1'b0;
      case ({aw_fire, b_fire})
        2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
        2'b01:   if (outstanding_q != '0) outstanding_q <= outstanding_q - OUT_W'(1);
        default: ;
      endcase
    end
  end

  // W framing: load one burst length at a time and count its beats down.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      loaded_q      <= 1'b0;
      beat_cnt_q    <= '0;
      w_remaining_q <= '0;
      done_q        <= 1'b0;
      resp_err_q    <= 1'b0;
      tlast_err_q   <= 1'b0;
    end else begin
      done_q <= finish;
      if (fifo_pop) begin
        loaded_q   <= 1'b1;
        beat_cnt_q <= fifo_dout;
      end else if (w_fire) begin
        if (beat_cnt_q == 8'd0) loaded_q <= 1'b0;
        else                    beat_cnt_q <= beat_cnt_q - 8'd1;
      end
      if (cmd_fire) begin
        w_remaining_q <= cmd_beats;
        resp_err_q    <= 1'b0;
        tlast_err_q   <= 1'b0;
      end else begin
        if (w_fire) w_remaining_q <= w_remaining_q - LEN_WIDTH'(1);
        if (b_fire && axi.m_s2mm_axi_bresp != 2'b00) resp_err_q <= 1'b1;
        if (w_fire && (axi.s_s2mm_axis_tlast != (w_remaining_q == LEN_WIDTH'(1))))
          tlast_err_q <= 1'b1;
      end
    end
  end

  burst_len_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (8)
  ) u_len_fifo (
    .clk   (m_axi_aclk),
    .rst_n (m_axi_aresetn),
    .push  (aw_fire),
    .din   (aw_len_q),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign axi.m_s2mm_axi_awvalid = aw_valid_q;
  assign axi.m_s2mm_axi_awaddr  = aw_addr_q;
  assign axi.m_s2mm_axi_awlen   = aw_len_q;
  assign axi.m_s2mm_axi_awsize  = 3'(SIZE_LOG2);
  assign axi.m_s2mm_axi_awburst = AXI_BURST_INCR;
  assign axi.m_s2mm_axi_awcache = AXI_CACHE_NORMAL_NC_BUF;
  assign axi.m_s2mm_axi_awprot  = 3'b000;

  assign axi.m_s2mm_axi_wdata   = axi.s_s2mm_axis_tdata;
  assign axi.m_s2mm_axi_wstrb   = '1;
  assign axi.m_s2mm_axi_wlast   = loaded_q && (beat_cnt_q == 8'd0);
  assign axi.m_s2mm_axi_wvalid  = axi.s_s2mm_axis_tvalid && loaded_q;
  assign axi.s_s2mm_axis_tready = axi.m_s2mm_axi_wready && loaded_q;
  assign axi.m_s2mm_axi_bready  = 1'b1;

  assign done_o      = done_q;
  assign resp_err_o  = resp_err_q;
  assign tlast_err_o = tlast_err_q;

endmodule
